// File: rtl/gpio_pad_pkg.sv
// Shared constants and types for the GPIO pad control stage: config word layout,
// drive-mode encodings, reset word and apply-sequencer states.
package gpio_pad_pkg;

  localparam int unsigned CFG_W = 13;

  localparam int unsigned CFG_DM_MSB      = 2;
  localparam int unsigned CFG_INP_DIS     = 3;
  localparam int unsigned CFG_IB_MODE_SEL = 4;
  localparam int unsigned CFG_VTRIP_SEL   = 5;
  localparam int unsigned CFG_SLOW        = 6;
  localparam int unsigned CFG_HLD_OVR     = 7;
  localparam int unsigned CFG_ANALOG_EN   = 8;
  localparam int unsigned CFG_ANALOG_SEL  = 9;
  localparam int unsigned CFG_ANALOG_POL  = 10;
  localparam int unsigned CFG_OE_BLOCK    = 11;
  localparam int unsigned CFG_DB_EN       = 12;

  localparam logic [2:0] DM_INPUT_ONLY = 3'b001;
  localparam logic [2:0] DM_STRONG     = 3'b110;

  typedef logic [CFG_W-1:0] cfg_word_t;

  localparam cfg_word_t CFG_RST = 13'h0001;

  typedef enum logic [1:0] {
    StIdle,
    StDisable,
    StApply,
    StSettle
  } cfg_state_e;

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// Serial configuration port of the pad control stage: shift/load strobes in,
// daisy-chain data and sequencer status out.
interface gpio_pad_ctrl_if;

  logic cfg_sin;
  logic cfg_shift;
  logic cfg_load;
  logic cfg_sout;
  logic cfg_busy;
  logic cfg_err;

  modport master (
    output cfg_sin,
    output cfg_shift,
    output cfg_load,
    input  cfg_sout,
    input  cfg_busy,
    input  cfg_err
  );

  modport slave (
    input  cfg_sin,
    input  cfg_shift,
    input  cfg_load,
    output cfg_sout,
    output cfg_busy,
    output cfg_err
  );

endinterface

// File: rtl/gpio_in_debounce.sv
// Pad input path: multi-flop synchronizer, optional stability-count debouncer
// and registered rise/fall pulses on the debounced value.
module gpio_in_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pad_in,
  input  logic             db_en,
  input  logic [CNT_W-1:0] debounce_limit,
  output logic             in_sync,
  output logic             in_db,
  output logic             in_rise,
  output logic             in_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, fall_q;

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign in_db   = db_q;
  assign in_rise = rise_q;
  assign in_fall = fall_q;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (!db_en) begin
      db_d  = in_sync;
      cnt_d = '0;
    end else if (in_sync == db_q) begin
      cnt_d = '0;
    end else if (cnt_q >= debounce_limit) begin
      // >= keeps the flip working if the limit is lowered mid-count
      db_d  = ~db_q;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Per-pad control stage: serial shadow config, glitch-safe apply sequencer
// (disable -> apply -> settle -> re-enable), registered pad drive and input path.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SETTLE_CYC  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  gpio_pad_ctrl_if.slave   cfg,
  input  logic             core_out,
  input  logic             core_oe,
  input  logic [CNT_W-1:0] debounce_limit,
  output logic             pad_out,
  output logic             pad_oe_n,
  output logic [2:0]       pad_dm,
  output logic             pad_inp_dis,
  output logic             pad_ib_mode_sel,
  output logic             pad_vtrip_sel,
  output logic             pad_slow,
  output logic             pad_hld_ovr,
  output logic             pad_analog_en,
  output logic             pad_analog_sel,
  output logic             pad_analog_pol,
  input  logic             pad_in,
  output logic             in_sync,
  output logic             in_db,
  output logic             in_rise,
  output logic             in_fall
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  cfg_state_e    state_q;
  cfg_word_t     shadow_q;
  cfg_word_t     active_q;
  logic [SW-1:0] settle_q;
  logic          cfg_err_q;
  logic          pad_out_q;
  logic          pad_oe_n_q;

  assign cfg.cfg_sout = shadow_q[CFG_W-1];
  assign cfg.cfg_busy = (state_q != StIdle);
  assign cfg.cfg_err  = cfg_err_q;

  assign pad_out         = pad_out_q;
  assign pad_oe_n        = pad_oe_n_q;
  assign pad_dm          = active_q[CFG_DM_MSB:0];
  assign pad_inp_dis     = active_q[CFG_INP_DIS];
  assign pad_ib_mode_sel = active_q[CFG_IB_MODE_SEL];
  assign pad_vtrip_sel   = active_q[CFG_VTRIP_SEL];
  assign pad_slow        = active_q[CFG_SLOW];
  assign pad_hld_ovr     = active_q[CFG_HLD_OVR];
  assign pad_analog_en   = active_q[CFG_ANALOG_EN];
  assign pad_analog_sel  = active_q[CFG_ANALOG_SEL];
  assign pad_analog_pol  = active_q[CFG_ANALOG_POL];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      shadow_q   <= CFG_RST;
      active_q   <= CFG_RST;
      settle_q   <= '0;
      cfg_err_q  <= 1'b0;
      pad_out_q  <= 1'b0;
      pad_oe_n_q <= 1'b1;
    end else begin
      if (cfg.cfg_shift) begin
        shadow_q <= {shadow_q[CFG_W-2:0], cfg.cfg_sin};
      end
      cfg_err_q  <= cfg.cfg_load && (state_q != StIdle);
      pad_out_q  <= core_out;
      // Driver stays off for the whole sequence so a half-applied mode never reaches the pad
      pad_oe_n_q <= ~(core_oe & ~active_q[CFG_OE_BLOCK] & (state_q == StIdle));
      unique case (state_q)
        StIdle: begin
          if (cfg.cfg_load) state_q <= StDisable;
        end
        StDisable: begin
          state_q <= StApply;
        end
        StApply: begin
          active_q <= shadow_q;
          settle_q <= SW'(SETTLE_CYC - 1);
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == '0) begin
            state_q <= StIdle;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  gpio_in_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) u_in_debounce (
    .clk            (clk),
    .resetn         (resetn),
    .pad_in         (pad_in),
    .db_en          (active_q[CFG_DB_EN]),
    .debounce_limit (debounce_limit),
    .in_sync        (in_sync),
    .in_db          (in_db),
    .in_rise        (in_rise),
    .in_fall        (in_fall)
  );

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: reset, apply sequencing, load-while-busy,
// debounce filtering and asynchronous reset mid-sequence.
module tb_gpio_pad_ctrl;
  import gpio_pad_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       core_out, core_oe;
  logic [7:0] debounce_limit;
  logic       pad_in;
  logic       pad_out, pad_oe_n;
  logic [2:0] pad_dm;
  logic       pad_inp_dis, pad_ib_mode_sel, pad_vtrip_sel, pad_slow, pad_hld_ovr;
  logic       pad_analog_en, pad_analog_sel, pad_analog_pol;
  logic       in_sync, in_db, in_rise, in_fall;

  int tests  = 0;
  int failed = 0;

  gpio_pad_ctrl_if cfg_bus ();

  gpio_pad_ctrl #(
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .SETTLE_CYC  (4)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cfg             (cfg_bus),
    .core_out        (core_out),
    .core_oe         (core_oe),
    .debounce_limit  (debounce_limit),
    .pad_out         (pad_out),
    .pad_oe_n        (pad_oe_n),
    .pad_dm          (pad_dm),
    .pad_inp_dis     (pad_inp_dis),
    .pad_ib_mode_sel (pad_ib_mode_sel),
    .pad_vtrip_sel   (pad_vtrip_sel),
    .pad_slow        (pad_slow),
    .pad_hld_ovr     (pad_hld_ovr),
    .pad_analog_en   (pad_analog_en),
    .pad_analog_sel  (pad_analog_sel),
    .pad_analog_pol  (pad_analog_pol),
    .pad_in          (pad_in),
    .in_sync         (in_sync),
    .in_db           (in_db),
    .in_rise         (in_rise),
    .in_fall         (in_fall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [12:0] w);
    for (int i = 12; i >= 0; i--) begin
      cfg_bus.cfg_sin   = w[i];
      cfg_bus.cfg_shift = 1'b1;
      step();
    end
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.cfg_sin   = 1'b0;
  endtask

  // Leaves the bench one tick after the edge that sampled cfg_load (k = 0).
  task automatic pulse_load();
    cfg_bus.cfg_load = 1'b1;
    step();
    cfg_bus.cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    tests++; if (pad_dm !== DM_INPUT_ONLY) begin failed++; $display("FAIL rst_dm got %b exp %b", pad_dm, DM_INPUT_ONLY); end
    tests++; if (pad_oe_n !== 1'b1) begin failed++; $display("FAIL rst_oe_n got %b exp 1", pad_oe_n); end
    tests++; if (cfg_bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL rst_busy got %b exp 0", cfg_bus.cfg_busy); end
    tests++; if (cfg_bus.cfg_err !== 1'b0) begin failed++; $display("FAIL rst_err got %b exp 0", cfg_bus.cfg_err); end
    tests++; if (pad_out !== 1'b0) begin failed++; $display("FAIL rst_pad_out got %b exp 0", pad_out); end
    tests++; if (in_db !== 1'b0) begin failed++; $display("FAIL rst_in_db got %b exp 0", in_db); end
    #3 resetn = 1'b1;
    step();
    pad_in = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      tests++; if (in_sync !== (j >= 2)) begin failed++; $display("FAIL rst_sync j=%0d got %b exp %b", j, in_sync, j >= 2); end
      tests++; if (in_db !== (j >= 3)) begin failed++; $display("FAIL rst_db j=%0d got %b exp %b", j, in_db, j >= 3); end
      tests++; if (in_rise !== (j == 3)) begin failed++; $display("FAIL rst_rise j=%0d got %b exp %b", j, in_rise, j == 3); end
    end
    pad_in = 1'b0;
    repeat (3) step();
    tests++; if (in_fall !== 1'b1) begin failed++; $display("FAIL rst_fall got %b exp 1", in_fall); end
    tests++; if (in_db !== 1'b0) begin failed++; $display("FAIL rst_db_low got %b exp 0", in_db); end
  endtask

  task automatic test_oe_block();
    core_oe = 1'b1;
    shift_word(13'h1806);
    tests++; if (cfg_bus.cfg_sout !== 1'b1) begin failed++; $display("FAIL blk_sout got %b exp 1", cfg_bus.cfg_sout); end
    pulse_load();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step();
      tests++; if (cfg_bus.cfg_busy !== (k <= 5)) begin failed++; $display("FAIL blk_busy k=%0d got %b exp %b", k, cfg_bus.cfg_busy, k <= 5); end
      tests++; if (pad_dm !== ((k >= 2) ? DM_STRONG : DM_INPUT_ONLY)) begin failed++; $display("FAIL blk_dm k=%0d got %b", k, pad_dm); end
      tests++; if (pad_oe_n !== (k != 0)) begin failed++; $display("FAIL blk_oe_n k=%0d got %b exp %b", k, pad_oe_n, k != 0); end
    end
  endtask

  task automatic test_oe_release();
    core_out = 1'b1;
    shift_word(13'h0006);
    tests++; if (cfg_bus.cfg_sout !== 1'b0) begin failed++; $display("FAIL rel_sout got %b exp 0", cfg_bus.cfg_sout); end
    pulse_load();
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      tests++; if (pad_oe_n !== (k <= 6)) begin failed++; $display("FAIL rel_oe_n k=%0d got %b exp %b", k, pad_oe_n, k <= 6); end
      tests++; if (pad_out !== 1'b1) begin failed++; $display("FAIL rel_out k=%0d got %b exp 1", k, pad_out); end
    end
  endtask

  task automatic test_load_while_busy();
    shift_word(13'h0003);
    pulse_load();
    step();
    // Second load plus a shift land on the APPLY edge
    cfg_bus.cfg_load  = 1'b1;
    cfg_bus.cfg_shift = 1'b1;
    cfg_bus.cfg_sin   = 1'b1;
    step();
    cfg_bus.cfg_load  = 1'b0;
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.cfg_sin   = 1'b0;
    tests++; if (cfg_bus.cfg_err !== 1'b1) begin failed++; $display("FAIL busy_err got %b exp 1", cfg_bus.cfg_err); end
    tests++; if (pad_dm !== 3'b011) begin failed++; $display("FAIL busy_dm got %b exp 011", pad_dm); end
    for (int k = 3; k <= 7; k++) begin
      step();
      tests++; if (cfg_bus.cfg_err !== 1'b0) begin failed++; $display("FAIL busy_err_clr k=%0d got %b exp 0", k, cfg_bus.cfg_err); end
      tests++; if (cfg_bus.cfg_busy !== (k <= 5)) begin failed++; $display("FAIL busy_len k=%0d got %b exp %b", k, cfg_bus.cfg_busy, k <= 5); end
    end
    tests++; if (pad_dm !== 3'b011 || pad_inp_dis !== 1'b0) begin failed++; $display("FAIL busy_active got dm=%b inp_dis=%b exp 011/0", pad_dm, pad_inp_dis); end
  endtask

  task automatic test_load_with_shift();
    // Shadow is 13'h0007; shifting a 0 alongside the load gives 13'h000E
    cfg_bus.cfg_load  = 1'b1;
    cfg_bus.cfg_shift = 1'b1;
    cfg_bus.cfg_sin   = 1'b0;
    step();
    cfg_bus.cfg_load  = 1'b0;
    cfg_bus.cfg_shift = 1'b0;
    tests++; if (cfg_bus.cfg_err !== 1'b0) begin failed++; $display("FAIL lws_err got %b exp 0", cfg_bus.cfg_err); end
    repeat (2) step();
    tests++; if (pad_dm !== DM_STRONG || pad_inp_dis !== 1'b1) begin failed++; $display("FAIL lws_active got dm=%b inp_dis=%b exp 110/1", pad_dm, pad_inp_dis); end
    repeat (6) step();
    tests++; if (cfg_bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL lws_idle got %b exp 0", cfg_bus.cfg_busy); end
  endtask

  task automatic test_debounce();
    logic seen_db, seen_rise;
    debounce_limit = 8'd5;
    shift_word(13'h1000);
    pulse_load();
    repeat (8) step();
    tests++; if (pad_dm !== 3'b000) begin failed++; $display("FAIL db_cfg_dm got %b exp 000", pad_dm); end
    seen_db   = 1'b0;
    seen_rise = 1'b0;
    pad_in = 1'b1;
    repeat (3) step();
    pad_in = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      seen_db   = seen_db | in_db;
      seen_rise = seen_rise | in_rise;
    end
    tests++; if (seen_db !== 1'b0) begin failed++; $display("FAIL db_glitch_db got %b exp 0", seen_db); end
    tests++; if (seen_rise !== 1'b0) begin failed++; $display("FAIL db_glitch_rise got %b exp 0", seen_rise); end
    for (int p = 1; p >= 0; p--) begin
      pad_in = p[0];
      for (int j = 1; j <= 12; j++) begin
        step();
        tests++; if (in_sync !== ((j >= 2) ? p[0] : ~p[0])) begin failed++; $display("FAIL db_sync p=%0d j=%0d got %b", p, j, in_sync); end
        tests++; if (in_db !== ((j >= 8) ? p[0] : ~p[0])) begin failed++; $display("FAIL db_val p=%0d j=%0d got %b", p, j, in_db); end
        tests++; if (in_rise !== (p == 1 && j == 8)) begin failed++; $display("FAIL db_rise p=%0d j=%0d got %b", p, j, in_rise); end
        tests++; if (in_fall !== (p == 0 && j == 8)) begin failed++; $display("FAIL db_fall p=%0d j=%0d got %b", p, j, in_fall); end
      end
    end
  endtask

  task automatic test_reset_mid();
    shift_word(13'h0006);
    pulse_load();
    repeat (3) step();
    tests++; if (cfg_bus.cfg_busy !== 1'b1 || pad_dm !== DM_STRONG) begin failed++; $display("FAIL mid_pre got busy=%b dm=%b exp 1/110", cfg_bus.cfg_busy, pad_dm); end
    #2 resetn = 1'b0;
    #1;
    tests++; if (pad_dm !== DM_INPUT_ONLY) begin failed++; $display("FAIL mid_dm got %b exp 001", pad_dm); end
    tests++; if (cfg_bus.cfg_busy !== 1'b0) begin failed++; $display("FAIL mid_busy got %b exp 0", cfg_bus.cfg_busy); end
    tests++; if (pad_oe_n !== 1'b1) begin failed++; $display("FAIL mid_oe_n got %b exp 1", pad_oe_n); end
    tests++; if (pad_out !== 1'b0) begin failed++; $display("FAIL mid_out got %b exp 0", pad_out); end
    #3 resetn = 1'b1;
    repeat (3) step();
    tests++; if (cfg_bus.cfg_busy !== 1'b0 || pad_dm !== DM_INPUT_ONLY) begin failed++; $display("FAIL mid_post got busy=%b dm=%b", cfg_bus.cfg_busy, pad_dm); end
  endtask

  initial begin
    resetn            = 1'b0;
    core_out          = 1'b0;
    core_oe           = 1'b0;
    debounce_limit    = 8'd5;
    pad_in            = 1'b0;
    cfg_bus.cfg_sin   = 1'b0;
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.cfg_load  = 1'b0;
    test_reset();
    test_oe_block();
    test_oe_release();
    test_load_while_busy();
    test_load_with_shift();
    test_debounce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
